// File: rtl/cache_miss_controller.sv
// Miss sequencer for the 4-way fully associative line array and block RAM.
// Handles one request at a time: lookup, dirty write-back, refill, line update.
module cache_miss_controller (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Req,
  input  logic       Write,
  input  logic [6:0] Address,
  input  logic [4:0] BlockIn,
  output logic       Done,
  output logic [4:0] BlockOut,
  output logic       HitOut,
  output logic       Busy,
  input  logic       L_Hit,
  input  logic [1:0] L_HitWay,
  input  logic [1:0] L_VictimWay,
  input  logic       L_VictimValid,
  input  logic       L_VictimDirty,
  input  logic [6:0] L_VictimTag,
  input  logic [4:0] L_Data,
  output logic       U_En,
  output logic       U_Touch,
  output logic [1:0] U_Way,
  output logic [6:0] U_Tag,
  output logic [4:0] U_Data,
  output logic       U_Dirty,
  output logic [6:0] M_Address,
  output logic [4:0] C_Block_M,
  output logic       C_Write_M,
  input  logic [4:0] M_Block_C
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_RD_ADDR,
    S_RD_WAIT,
    S_FILL,
    S_RESP
  } state_t;

  state_t     r_state;
  logic [6:0] r_addr;
  logic       r_write;
  logic [4:0] r_din;
  logic [1:0] r_vway;
  logic       r_done;
  logic [4:0] r_bout;
  logic       r_hit;
  logic       r_uen;
  logic       r_utouch;
  logic [1:0] r_uway;
  logic [4:0] r_udata;
  logic       r_udirty;
  logic [6:0] r_maddr;
  logic [4:0] r_cdata;
  logic       r_cwr;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_din    <= '0;
      r_vway   <= '0;
      r_done   <= 1'b0;
      r_bout   <= '0;
      r_hit    <= 1'b0;
      r_uen    <= 1'b0;
      r_utouch <= 1'b0;
      r_uway   <= '0;
      r_udata  <= '0;
      r_udirty <= 1'b0;
      r_maddr  <= '0;
      r_cdata  <= '0;
      r_cwr    <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_uen    <= 1'b0;
      r_utouch <= 1'b0;
      r_cwr    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (Req) begin
            r_addr  <= Address;
            r_write <= Write;
            r_din   <= BlockIn;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit  <= L_Hit;
          r_vway <= L_VictimWay;
          if (L_Hit) begin
            r_uway   <= L_HitWay;
            r_utouch <= 1'b1;
            if (r_write) begin
              r_uen    <= 1'b1;
              r_udata  <= r_din;
              r_udirty <= 1'b1;
            end else begin
              r_bout <= L_Data;
            end
            r_state <= S_RESP;
          end else if (L_VictimValid && L_VictimDirty) begin
            r_cwr   <= 1'b1;
            r_maddr <= L_VictimTag;
            r_cdata <= L_Data;
            r_state <= S_WB;
          end else if (r_write) begin
            // one-word blocks: write-allocate installs without a fetch
            r_uen    <= 1'b1;
            r_utouch <= 1'b1;
            r_uway   <= L_VictimWay;
            r_udata  <= r_din;
            r_udirty <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_maddr <= r_addr;
            r_state <= S_RD_ADDR;
          end
        end
        S_WB: begin
          if (r_write) begin
            r_uen    <= 1'b1;
            r_utouch <= 1'b1;
            r_uway   <= r_vway;
            r_udata  <= r_din;
            r_udirty <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_maddr <= r_addr;
            r_state <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_uen    <= 1'b1;
          r_utouch <= 1'b1;
          r_uway   <= r_vway;
          r_udata  <= M_Block_C;
          r_udirty <= 1'b0;
          r_bout   <= M_Block_C;
          r_state  <= S_FILL;
        end
        S_FILL: r_state <= S_RESP;
        S_RESP: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Done      = r_done;
  assign BlockOut  = r_bout;
  assign HitOut    = r_hit;
  assign Busy      = (r_state != S_IDLE);
  assign U_En      = r_uen;
  assign U_Touch   = r_utouch;
  assign U_Way     = r_uway;
  assign U_Tag     = r_addr;
  assign U_Data    = r_udata;
  assign U_Dirty   = r_udirty;
  assign M_Address = r_maddr;
  assign C_Block_M = r_cdata;
  assign C_Write_M = r_cwr;

endmodule
